// File: rtl/aucohl_adc_seq_if.sv
// Sequencer-to-ADC-controller and sequencer-to-result-FIFO signal bundle.
// master = sequencer side, slave = ADC controller / FIFO side.
interface aucohl_adc_seq_if #(
    parameter int CW   = 3,
    parameter int SIZE = 8
);
    logic [CW-1:0]      ch_sel;
    logic               adc_soc;
    logic               adc_eoc;
    logic [SIZE-1:0]    adc_data;
    logic               fifo_wr;
    logic [CW+SIZE-1:0] fifo_wdata;
    logic               fifo_full;

    modport master (
        output ch_sel, adc_soc, fifo_wr, fifo_wdata,
        input  adc_eoc, adc_data, fifo_full
    );

    modport slave (
        input  ch_sel, adc_soc, fifo_wr, fifo_wdata,
        output adc_eoc, adc_data, fifo_full
    );
endinterface

// File: rtl/aucohl_adc_seq.sv
// Multi-channel scan sequencer: walks enabled channels, runs 2^avg conversions
// per channel, pushes {channel, average} into the result FIFO.
//
// state | meaning
// IDLE  | waiting for start pulse or period-timer expiry
// NEXT  | examine ch_mask[idx]; select channel or advance
// SOC   | one-cycle start-of-conversion pulse
// WAIT  | wait for adc_eoc, accumulate result
// PUSH  | write averaged result to FIFO (or flag ovf when full)
// DONE  | one-cycle done pulse
module aucohl_adc_seq #(
    parameter int NCH  = 8,
    parameter int CW   = 3,
    parameter int SIZE = 8,
    parameter int TW   = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_en,
    input  logic            i_start,
    input  logic            i_mode,
    input  logic [TW-1:0]   i_period,
    input  logic [NCH-1:0]  i_ch_mask,
    input  logic [1:0]      i_avg,
    input  logic            i_clr,
    aucohl_adc_seq_if.master bus,
    output logic            o_busy,
    output logic            o_done,
    output logic            o_ovf,
    output logic            o_miss
);
    localparam int ACW = SIZE + 3;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        NEXT = 3'd1,
        SOC  = 3'd2,
        WAIT = 3'd3,
        PUSH = 3'd4,
        DONE = 3'd5
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [CW-1:0]   r_idx;
    logic [CW-1:0]   r_ch_sel;
    logic [ACW-1:0]  r_acc;
    logic [2:0]      r_cnt;
    logic [TW-1:0]   r_timer;
    logic            r_running;
    logic            r_ovf;
    logic            r_miss;

    logic            w_expire;
    logic            w_trig;
    logic            w_idx_last;
    logic            w_cnt_last;
    logic [2:0]      w_cnt_max;
    logic [SIZE-1:0] w_avg_res;
    logic            w_ovf_set;
    logic            w_miss_set;

    assign w_expire   = i_mode & i_en & r_running & (r_timer == '0);
    assign w_trig     = (r_state == IDLE) & i_en & (i_start | w_expire);
    assign w_idx_last = (r_idx == CW'(NCH - 1));
    assign w_cnt_max  = 3'((4'd1 << i_avg) - 4'd1);
    assign w_cnt_last = (r_cnt == w_cnt_max);
    assign w_avg_res  = SIZE'(r_acc >> i_avg);

    // With period=0 the timer expires every cycle; only IDLE expiries matter.
    assign w_miss_set = w_expire & (r_state != IDLE) & (i_period != '0);
    assign w_ovf_set  = i_en & (r_state == PUSH) & bus.fifo_full;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_trig) begin
                    w_state_nxt = NEXT;
                end
            end
            NEXT: begin
                if (i_ch_mask[r_idx]) begin
                    w_state_nxt = SOC;
                end else if (w_idx_last) begin
                    w_state_nxt = DONE;
                end
            end
            SOC: begin
                w_state_nxt = WAIT;
            end
            WAIT: begin
                if (bus.adc_eoc) begin
                    w_state_nxt = w_cnt_last ? PUSH : SOC;
                end
            end
            PUSH: begin
                w_state_nxt = w_idx_last ? DONE : NEXT;
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
        if (!i_en) begin
            w_state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx    <= '0;
            r_ch_sel <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
        end else if (!i_en) begin
            r_acc <= '0;
            r_cnt <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_trig) begin
                        r_idx <= '0;
                        r_acc <= '0;
                        r_cnt <= '0;
                    end
                end
                NEXT: begin
                    if (i_ch_mask[r_idx]) begin
                        r_ch_sel <= r_idx;
                    end else if (!w_idx_last) begin
                        r_idx <= r_idx + CW'(1);
                    end
                end
                WAIT: begin
                    if (bus.adc_eoc) begin
                        r_acc <= r_acc + ACW'(bus.adc_data);
                        r_cnt <= r_cnt + 3'd1;
                    end
                end
                PUSH: begin
                    r_acc <= '0;
                    r_cnt <= '0;
                    if (!w_idx_last) begin
                        r_idx <= r_idx + CW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Period timer keeps running through a scan so the scan period is exact.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_timer   <= '0;
            r_running <= 1'b0;
        end else begin
            if (!i_en) begin
                r_timer <= '0;
            end else if (w_trig) begin
                r_timer <= i_period;
            end else if (i_mode && r_running) begin
                r_timer <= (r_timer == '0) ? i_period : r_timer - TW'(1);
            end

            if (!i_mode || !i_en) begin
                r_running <= 1'b0;
            end else if (i_start) begin
                r_running <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf  <= 1'b0;
            r_miss <= 1'b0;
        end else begin
            r_ovf  <= w_ovf_set  | (r_ovf  & ~i_clr);
            r_miss <= w_miss_set | (r_miss & ~i_clr);
        end
    end

    assign bus.ch_sel     = r_ch_sel;
    assign bus.adc_soc    = i_en & (r_state == SOC);
    assign bus.fifo_wr    = i_en & (r_state == PUSH) & ~bus.fifo_full;
    assign bus.fifo_wdata = {r_idx, w_avg_res};

    assign o_busy = (r_state != IDLE);
    assign o_done = i_en & (r_state == DONE);
    assign o_ovf  = r_ovf;
    assign o_miss = r_miss;
endmodule

// File: tb/tb_aucohl_adc_seq.sv
// Directed bench for aucohl_adc_seq with a simple ADC model (eoc 10 cycles
// after soc) and a FIFO-write logger.
module tb_aucohl_adc_seq;
    logic        clk;
    logic        rst_n;
    logic        en;
    logic        start;
    logic        mode;
    logic [15:0] period;
    logic [7:0]  ch_mask;
    logic [1:0]  avg;
    logic        clr;
    logic        busy;
    logic        done;
    logic        ovf;
    logic        miss;

    aucohl_adc_seq_if #(.CW(3), .SIZE(8)) bus ();

    aucohl_adc_seq #(.NCH(8), .CW(3), .SIZE(8), .TW(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_en      (en),
        .i_start   (start),
        .i_mode    (mode),
        .i_period  (period),
        .i_ch_mask (ch_mask),
        .i_avg     (avg),
        .i_clr     (clr),
        .bus       (bus),
        .o_busy    (busy),
        .o_done    (done),
        .o_ovf     (ovf),
        .o_miss    (miss)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    int          soc_count;
    int          soc_cyc[$];
    int          soc_ch[$];
    int          wr_q[$];
    int          done_count;
    int          done_q[$];
    int          busy_fall_cyc;
    logic        prev_busy = 1'b0;
    int          pend = 0;
    logic [2:0]  pend_ch = '0;
    bit          data_mode = 1'b0;
    int          seq_idx = 0;
    logic [7:0]  seq_data [4];

    // ADC model and activity logger, sampled on the falling edge.
    always @(negedge clk) begin
        bus.adc_eoc = 1'b0;
        if (pend > 0) begin
            pend--;
            if (pend == 0) begin
                bus.adc_eoc = 1'b1;
                if (data_mode) begin
                    bus.adc_data = seq_data[seq_idx % 4];
                    seq_idx++;
                end else begin
                    bus.adc_data = 8'h40 + 8'(pend_ch);
                end
            end
        end
        if (bus.adc_soc) begin
            soc_count++;
            soc_cyc.push_back(cyc);
            soc_ch.push_back(int'(bus.ch_sel));
            pend    = 10;
            pend_ch = bus.ch_sel;
        end
        if (bus.fifo_wr) wr_q.push_back(int'(bus.fifo_wdata));
        if (done) begin
            done_count++;
            done_q.push_back(cyc);
        end
        if (prev_busy && !busy) busy_fall_cyc = cyc;
        prev_busy = busy;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        soc_count = 0;
        soc_cyc.delete();
        soc_ch.delete();
        wr_q.delete();
        done_count = 0;
        done_q.delete();
        busy_fall_cyc = -1;
        seq_idx = 0;
    endtask

    task automatic pulse_start(output int s);
        start = 1'b1;
        s = cyc;
        tick(1);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n0;
        int k;
        n0 = done_count;
        k = 0;
        while (done_count == n0 && k < budget) begin
            tick(1);
            k++;
        end
        check_val(tag, done_count != n0, 1);
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int k;
        k = 0;
        while (busy && k < budget) begin
            tick(1);
            k++;
        end
        check_val(tag, busy, 0);
    endtask

    initial begin
        int s;
        int bad;
        seq_data[0] = 8'd10;
        seq_data[1] = 8'd11;
        seq_data[2] = 8'd12;
        seq_data[3] = 8'd13;
        rst_n = 1'b0; en = 1'b0; start = 1'b0; mode = 1'b0; period = '0;
        ch_mask = '0; avg = '0; clr = 1'b0;
        bus.fifo_full = 1'b0; bus.adc_eoc = 1'b0; bus.adc_data = '0;
        clear_log();
        tick(3);
        check_val("rst_busy", busy, 0);
        check_val("rst_done", done, 0);
        check_val("rst_ovf", ovf, 0);
        check_val("rst_miss", miss, 0);
        check_val("rst_chsel", bus.ch_sel, 0);
        check_val("rst_soc", bus.adc_soc, 0);
        check_val("rst_wr", bus.fifo_wr, 0);
        rst_n = 1'b1;
        en = 1'b1;
        tick(2);

        // basic scan, channels 0 and 2
        clear_log();
        ch_mask = 8'b0000_0101;
        avg = 2'd0;
        pulse_start(s);
        wait_done("basic_timeout", 200);
        tick(2);
        check_val("basic_soc_lat", (soc_cyc.size() > 0) ? soc_cyc[0] - s : -1, 2);
        check_val("basic_soc_cnt", soc_count, 2);
        check_val("basic_ch0", (soc_ch.size() > 0) ? soc_ch[0] : -1, 0);
        check_val("basic_ch1", (soc_ch.size() > 1) ? soc_ch[1] : -1, 2);
        check_val("basic_wr_cnt", wr_q.size(), 2);
        check_val("basic_wr0", (wr_q.size() > 0) ? wr_q[0] : -1, 32'h040);
        check_val("basic_wr1", (wr_q.size() > 1) ? wr_q[1] : -1, 32'h242);
        check_val("basic_done_cnt", done_count, 1);
        check_val("basic_busy_fall", busy_fall_cyc, (done_q.size() > 0) ? done_q[0] + 1 : -2);

        // averaging: 4 conversions on channel 3, (10+11+12+13)>>2 = 11
        clear_log();
        data_mode = 1'b1;
        ch_mask = 8'b0000_1000;
        avg = 2'd2;
        pulse_start(s);
        wait_done("avg_timeout", 300);
        tick(2);
        bad = 0;
        foreach (soc_ch[i]) if (soc_ch[i] != 3) bad++;
        check_val("avg_soc_cnt", soc_count, 4);
        check_val("avg_ch_bad", bad, 0);
        check_val("avg_wr_cnt", wr_q.size(), 1);
        check_val("avg_wr0", (wr_q.size() > 0) ? wr_q[0] : -1, 32'h30B);
        data_mode = 1'b0;
        avg = 2'd0;

        // FIFO full: results dropped, ovf set, clr clears it
        clear_log();
        bus.fifo_full = 1'b1;
        ch_mask = 8'h03;
        pulse_start(s);
        wait_done("full_timeout", 200);
        tick(2);
        check_val("full_wr_cnt", wr_q.size(), 0);
        check_val("full_ovf", ovf, 1);
        check_val("full_done_cnt", done_count, 1);
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        check_val("full_clr_ovf", ovf, 0);
        bus.fifo_full = 1'b0;

        // continuous, period 99: channel-0 soc every 100 cycles
        clear_log();
        ch_mask = 8'h01;
        mode = 1'b1;
        period = 16'd99;
        pulse_start(s);
        for (int k = 0; k < 400 && soc_count < 3; k++) tick(1);
        check_val("cont_soc_cnt", soc_count >= 3, 1);
        check_val("cont_gap1", (soc_cyc.size() > 1) ? soc_cyc[1] - soc_cyc[0] : -1, 100);
        check_val("cont_gap2", (soc_cyc.size() > 2) ? soc_cyc[2] - soc_cyc[1] : -1, 100);
        check_val("cont_miss", miss, 0);
        mode = 1'b0;
        wait_idle("cont_stop", 200);

        // miss: period 5 with a ~21-cycle scan; expiries every 6 cycles from s+6,
        // DONE at s+21, first idle expiry at s+24, its soc at s+26
        clear_log();
        mode = 1'b1;
        period = 16'd5;
        pulse_start(s);
        for (int k = 0; k < 200 && soc_count < 2; k++) tick(1);
        check_val("miss_flag", miss, 1);
        check_val("miss_gap", (soc_cyc.size() > 1) ? soc_cyc[1] - soc_cyc[0] : -1, 24);
        mode = 1'b0;
        wait_idle("miss_stop", 200);
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        check_val("miss_clr", miss, 0);

        // period 0: back-to-back empty scans, done every 10 cycles, no miss
        clear_log();
        ch_mask = 8'h00;
        mode = 1'b1;
        period = 16'd0;
        pulse_start(s);
        for (int k = 0; k < 100 && done_count < 2; k++) tick(1);
        check_val("p0_gap", (done_q.size() > 1) ? done_q[1] - done_q[0] : -1, 10);
        check_val("p0_miss", miss, 0);
        mode = 1'b0;
        wait_idle("p0_stop", 50);

        // abort during WAIT: busy drops next cycle, late eoc ignored
        clear_log();
        ch_mask = 8'h01;
        pulse_start(s);
        tick(4);
        check_val("abort_in_wait", soc_count, 1);
        en = 1'b0;
        tick(1);
        check_val("abort_busy", busy, 0);
        en = 1'b1;
        tick(20);
        check_val("abort_wr", wr_q.size(), 0);
        check_val("abort_done", done_count, 0);
        check_val("abort_idle", busy, 0);

        // empty mask: 8 NEXT cycles then DONE at s+9
        clear_log();
        ch_mask = 8'h00;
        pulse_start(s);
        wait_done("empty_timeout", 50);
        tick(1);
        check_val("empty_done_cyc", (done_q.size() > 0) ? done_q[0] - s : -1, 9);
        check_val("empty_soc", soc_count, 0);
        check_val("empty_wr", wr_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout got=%0d exp=0", cyc);
        $fatal(1, "bench watchdog expired");
    end
endmodule
